// File: rtl/tdm_demux.sv
//==============================================================================
// Module   : tdm_demux
// Brief    : Time-division demultiplexer. Collects a framed serial stream of
//            W-bit beats (channel 0 marked by in_sof) into an N_CH-slot
//            shadow buffer and releases each complete frame as one registered
//            parallel word with a one-cycle valid strobe. Framing errors
//            (beat without SOF while hunting, premature SOF while collecting)
//            raise a one-cycle err_sync pulse.
// Options  : TDM_DEMUX_ERRCNT_EN - adds err_count, an 8-bit saturating count
//            of err_sync pulses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [N_CH*W-1:0] out_data,
    output logic              out_valid,
    output logic              err_sync
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int            CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(N_CH - 1);
    localparam logic [CW-1:0] c_ONE  = CW'(1);

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [N_CH*W-1:0]   r_shadow;
    logic [N_CH*W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_err_sync;

    logic                w_start;
    logic                w_beat;
    logic                w_done;
    logic                w_err;
    logic [CW-1:0]       w_slot;
    int                  w_base;
    logic [N_CH*W-1:0]   w_shadow_nxt;

    // Any SOF beat restarts a frame; a non-SOF beat only counts while collecting.
    // The final beat of a frame carrying SOF is therefore a premature SOF.
    assign w_start = in_valid & in_sof;
    assign w_beat  = in_valid & ~in_sof & (r_state == COLLECT);
    assign w_done  = w_beat & (r_cnt == c_LAST);
    assign w_err   = in_valid & ((r_state == HUNT) ? ~in_sof : in_sof);
    assign w_slot  = w_beat ? r_cnt : '0;

    // Shadow buffer as it looks once the current beat is written; on
    // completion this whole word is what gets published.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_base       = int'(w_slot) * W;
        w_shadow_nxt[w_base +: W] = in_data;
    end

    // Framing FSM, shadow buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err_sync  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_err_sync  <= w_err;
            if (w_start) begin
                // Fresh frame: a partial frame in progress is simply overwritten.
                r_shadow <= w_shadow_nxt;
                r_cnt    <= c_ONE;
                r_state  <= COLLECT;
            end else if (w_beat) begin
                r_shadow <= w_shadow_nxt;
                if (w_done) begin
                    r_out_data  <= w_shadow_nxt;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= HUNT;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign err_sync  = r_err_sync;

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating error counter, updated on the same edge that raises err_sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
//==============================================================================
// Module   : tb_tdm_demux
// Brief    : Self-checking bench for tdm_demux (N_CH=4, W=8). Directed vector
//            table plus hand-written back-to-back and saturation sequences.
//            Build with TDM_DEMUX_ERRCNT_EN defined to cover err_count.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst;
    logic [W-1:0]      in_data;
    logic              in_valid;
    logic              in_sof;
    logic [N_CH*W-1:0] out_data;
    logic              out_valid;
    logic              err_sync;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]        err_count;
`endif

    int n_checks;
    int n_errors;

    tdm_demux #(
        .N_CH (N_CH),
        .W    (W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .err_sync  (err_sync)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              v;
        logic              sof;
        logic [W-1:0]      d;
        logic              e_ov;
        logic              e_es;
        logic [N_CH*W-1:0] e_od;
        logic [7:0]        e_ec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic s,
                                input logic [W-1:0] d, input logic ov,
                                input logic es, input logic [N_CH*W-1:0] od,
                                input logic [7:0] ec);
        vec_t t;
        t.rst = r; t.v = v; t.sof = s; t.d = d;
        t.e_ov = ov; t.e_es = es; t.e_od = od; t.e_ec = ec;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        rst = r; in_valid = v; in_sof = s; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N_CH*W-1:0] frm;
        logic [W-1:0]      b;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;

        // ---------------- vector table ----------------
        // reset state
        add(1,0,0,8'h00, 0,0,32'h0,        8'd0);
        add(1,0,0,8'h00, 0,0,32'h0,        8'd0);
        // clean frame
        add(0,1,1,8'h11, 0,0,32'h0,        8'd0);
        add(0,1,0,8'h22, 0,0,32'h0,        8'd0);
        add(0,1,0,8'h33, 0,0,32'h0,        8'd0);
        add(0,1,0,8'h44, 1,0,32'h44332211, 8'd0);
        add(0,0,0,8'h00, 0,0,32'h44332211, 8'd0);
        // gapped frame (3 idle cycles between beats)
        add(0,1,1,8'h11, 0,0,32'h44332211, 8'd0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 0,0,32'h44332211, 8'd0);
        add(0,1,0,8'h22, 0,0,32'h44332211, 8'd0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 0,0,32'h44332211, 8'd0);
        add(0,1,0,8'h33, 0,0,32'h44332211, 8'd0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 0,0,32'h44332211, 8'd0);
        add(0,1,0,8'h44, 1,0,32'h44332211, 8'd0);
        add(0,0,0,8'h00, 0,0,32'h44332211, 8'd0);
        // premature SOF
        add(0,1,1,8'hA1, 0,0,32'h44332211, 8'd0);
        add(0,1,0,8'hA2, 0,0,32'h44332211, 8'd0);
        add(0,1,1,8'hB1, 0,1,32'h44332211, 8'd1);
        add(0,1,0,8'hB2, 0,0,32'h44332211, 8'd1);
        add(0,1,0,8'hB3, 0,0,32'h44332211, 8'd1);
        add(0,1,0,8'hB4, 1,0,32'hB4B3B2B1, 8'd1);
        // SOF on the would-be completion beat: error, no out_valid
        add(0,1,1,8'h01, 0,0,32'hB4B3B2B1, 8'd1);
        add(0,1,0,8'h02, 0,0,32'hB4B3B2B1, 8'd1);
        add(0,1,0,8'h03, 0,0,32'hB4B3B2B1, 8'd1);
        add(0,1,1,8'h04, 0,1,32'hB4B3B2B1, 8'd2);
        add(0,1,0,8'h05, 0,0,32'hB4B3B2B1, 8'd2);
        add(0,1,0,8'h06, 0,0,32'hB4B3B2B1, 8'd2);
        add(0,1,0,8'h07, 1,0,32'h07060504, 8'd2);
        // hunt discard after reset
        add(1,0,0,8'h00, 0,0,32'h0,        8'd0);
        add(0,1,0,8'h55, 0,1,32'h0,        8'd1);
        add(0,1,0,8'h66, 0,1,32'h0,        8'd2);
        add(0,0,0,8'h00, 0,0,32'h0,        8'd2);
        add(0,1,1,8'h01, 0,0,32'h0,        8'd2);
        add(0,1,0,8'h02, 0,0,32'h0,        8'd2);
        add(0,1,0,8'h03, 0,0,32'h0,        8'd2);
        add(0,1,0,8'h04, 1,0,32'h04030201, 8'd2);
        // reset mid-frame
        add(0,1,1,8'h77, 0,0,32'h04030201, 8'd2);
        add(0,1,0,8'h78, 0,0,32'h04030201, 8'd2);
        add(0,1,0,8'h79, 0,0,32'h04030201, 8'd2);
        add(1,0,0,8'h00, 0,0,32'h0,        8'd0);
        add(0,1,0,8'h7A, 0,1,32'h0,        8'd1);
        add(0,1,1,8'h81, 0,0,32'h0,        8'd1);
        add(0,1,0,8'h82, 0,0,32'h0,        8'd1);
        add(0,1,0,8'h83, 0,0,32'h0,        8'd1);
        add(0,1,0,8'h84, 1,0,32'h84838281, 8'd1);
        add(0,0,0,8'h00, 0,0,32'h84838281, 8'd1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].sof, vecs[i].d);
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d err_sync", i),  64'(err_sync),  64'(vecs[i].e_es));
            chk($sformatf("vec%0d out_data", i),  64'(out_data),  64'(vecs[i].e_od));
`ifdef TDM_DEMUX_ERRCNT_EN
            chk($sformatf("vec%0d err_count", i), 64'(err_count), 64'(vecs[i].e_ec));
`endif
        end

        // ---------------- back-to-back frames ----------------
        frm = 32'h84838281;
        for (int f = 0; f < 3; f++) begin
            logic [N_CH*W-1:0] nf;
            nf = '0;
            for (int k = 0; k < N_CH; k++) begin
                b = W'(8'hC0 + f * 16 + k);
                nf[k*W +: W] = b;
                step(1'b0, 1'b1, (k == 0), b);
                chk($sformatf("b2b f%0d k%0d out_valid", f, k), 64'(out_valid), 64'(k == N_CH - 1));
                chk($sformatf("b2b f%0d k%0d err_sync", f, k),  64'(err_sync),  64'd0);
                if (k == N_CH - 1) frm = nf;
                chk($sformatf("b2b f%0d k%0d out_data", f, k),  64'(out_data),  64'(frm));
            end
        end

`ifdef TDM_DEMUX_ERRCNT_EN
        // ---------------- error counter saturation ----------------
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("sat reset err_count", 64'(err_count), 64'd0);
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'hEE);
            if (i == 254 || i == 255 || i == 256 || i == 300) begin
                chk($sformatf("sat %0d err_count", i), 64'(err_count), 64'(i > 255 ? 255 : i));
                chk($sformatf("sat %0d err_sync", i),  64'(err_sync),  64'd1);
            end
        end
`endif

        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("final idle err_sync", 64'(err_sync), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
